// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one op at a time, steers bytes onto a gnt/rvalid bus and extends load data.
// Optional LSU_BUS_TIMEOUT_EN bounds the REQ/WAIT_R waits with TIMEOUT_CYCLES and reports resp_bus_error.
module load_store_unit #(
  parameter int XLEN           = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_store,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [XLEN-1:0]       req_wdata,
  output logic                  resp_valid,
  output logic [XLEN-1:0]       resp_rdata,
  output logic                  resp_misaligned,
  output logic                  resp_illegal,
  output logic                  resp_bus_error,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [XLEN-1:0]       mem_wdata,
  output logic [XLEN/8-1:0]     mem_be,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [XLEN-1:0]       mem_rdata
);

  localparam int BW = XLEN / 8;
  localparam int OW = $clog2(BW);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, RESP} state_t;

  state_t                state_q, state_d;
  logic                  is_store_q, is_store_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [XLEN-1:0]       wdata_q, wdata_d;
  logic [XLEN-1:0]       rdata_q, rdata_d;
  logic                  mis_q, mis_d;
  logic                  ill_q, ill_d;
  logic                  berr_q, berr_d;

  logic [OW-1:0]   req_off, off_q;
  logic            req_ill, req_mis;
  logic [3:0]      nbytes;
  logic [BW-1:0]   size_mask;
  logic [XLEN-1:0] shifted, ld_data;
  logic            in_req, tmo_hit;

  assign req_off = req_addr[OW-1:0];
  assign off_q   = addr_q[OW-1:0];
  assign in_req  = (state_q == REQ);

  // Double-word accesses (funct3[1:0] == 3) and LWU exist only on a 64-bit datapath.
  always_comb begin
    req_ill = 1'b0;
    req_mis = 1'b0;
    if (req_is_store) begin
      req_ill = req_funct3[2] || ((req_funct3[1:0] == 2'd3) && (XLEN != 64));
    end else begin
      req_ill = (req_funct3 == 3'd7) ||
                (((req_funct3 == 3'd3) || (req_funct3 == 3'd6)) && (XLEN != 64));
    end
    case (req_funct3[1:0])
      2'd1:    req_mis = req_off[0];
      2'd2:    req_mis = |req_off[1:0];
      2'd3:    req_mis = |req_off;
      default: req_mis = 1'b0;
    endcase
  end

  always_comb begin
    nbytes = 4'd1 << funct3_q[1:0];
    for (int i = 0; i < BW; i++) begin
      size_mask[i] = (4'(i) < nbytes);
    end
  end

  always_comb begin
    shifted = mem_rdata >> {off_q, 3'b000};
    case (funct3_q[1:0])
      2'd0:    ld_data = funct3_q[2] ? XLEN'(shifted[7:0])  : XLEN'($signed(shifted[7:0]));
      2'd1:    ld_data = funct3_q[2] ? XLEN'(shifted[15:0]) : XLEN'($signed(shifted[15:0]));
      2'd2:    ld_data = funct3_q[2] ? XLEN'(shifted[31:0]) : XLEN'($signed(shifted[31:0]));
      default: ld_data = shifted;
    endcase
  end

`ifdef LSU_BUS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;

  assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  // Restarts on every state change so REQ and WAIT_R each get a full budget.
  always_comb begin
    tmo_d = '0;
    if ((state_d == state_q) && ((state_q == REQ) || (state_q == WAIT_R))) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    funct3_d   = funct3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    mis_d      = mis_q;
    ill_d      = ill_q;
    berr_d     = berr_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          is_store_d = req_is_store;
          funct3_d   = req_funct3;
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          rdata_d    = '0;
          ill_d      = req_ill;
          mis_d      = !req_ill && req_mis;
          berr_d     = 1'b0;
          state_d    = (req_ill || req_mis) ? RESP : REQ;
        end
      end
      REQ: begin
        if (mem_gnt) begin
          state_d = is_store_q ? RESP : WAIT_R;
        end else if (tmo_hit) begin
          berr_d  = 1'b1;
          state_d = RESP;
        end
      end
      WAIT_R: begin
        if (mem_rvalid) begin
          rdata_d = ld_data;
          state_d = RESP;
        end else if (tmo_hit) begin
          berr_d  = 1'b1;
          state_d = RESP;
        end
      end
      default: begin
        rdata_d = '0;
        mis_d   = 1'b0;
        ill_d   = 1'b0;
        berr_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      is_store_q <= 1'b0;
      funct3_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      mis_q      <= 1'b0;
      ill_q      <= 1'b0;
      berr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      funct3_q   <= funct3_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      mis_q      <= mis_d;
      ill_q      <= ill_d;
      berr_q     <= berr_d;
    end
  end

  assign req_ready       = (state_q == IDLE);
  assign resp_valid      = (state_q == RESP);
  assign resp_rdata      = resp_valid ? rdata_q : '0;
  assign resp_misaligned = resp_valid && mis_q;
  assign resp_illegal    = resp_valid && ill_q;
  assign resp_bus_error  = resp_valid && berr_q;

  // Bus outputs come straight from the latched request, so they hold steady through a stall.
  assign mem_req   = in_req;
  assign mem_we    = in_req && is_store_q;
  assign mem_addr  = in_req ? {addr_q[ADDR_WIDTH-1:OW], {OW{1'b0}}} : '0;
  assign mem_wdata = in_req ? (wdata_q << {off_q, 3'b000}) : '0;
  assign mem_be    = in_req ? (size_mask << off_q) : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed table-driven bench for load_store_unit, exercising an XLEN=32 and an XLEN=64 instance.
// Build with LSU_BUS_TIMEOUT_EN defined to add the bus-timeout sequence.
module tb_load_store_unit;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel64;
  logic        req_valid, req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [63:0] mem_rdata;

  logic        r32_ready, r32_rv, r32_mis, r32_ill, r32_berr, r32_req, r32_we;
  logic [31:0] r32_rdata, r32_addr, r32_wdata;
  logic [3:0]  r32_be;
  logic        r64_ready, r64_rv, r64_mis, r64_ill, r64_berr, r64_req, r64_we;
  logic [63:0] r64_rdata, r64_wdata;
  logic [31:0] r64_addr;
  logic [7:0]  r64_be;

  logic        o_ready, o_rv, o_mis, o_ill, o_berr, o_req, o_we;
  logic [63:0] o_rdata, o_wdata;
  logic [31:0] o_addr;
  logic [7:0]  o_be;

  always #5 clk = ~clk;

  load_store_unit #(.XLEN(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TMO)) u32 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid && !sel64), .req_ready(r32_ready),
    .req_is_store(req_is_store), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata[31:0]),
    .resp_valid(r32_rv), .resp_rdata(r32_rdata), .resp_misaligned(r32_mis),
    .resp_illegal(r32_ill), .resp_bus_error(r32_berr),
    .mem_req(r32_req), .mem_we(r32_we), .mem_addr(r32_addr), .mem_wdata(r32_wdata),
    .mem_be(r32_be), .mem_gnt(mem_gnt && !sel64), .mem_rvalid(mem_rvalid && !sel64),
    .mem_rdata(mem_rdata[31:0])
  );

  load_store_unit #(.XLEN(64), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TMO)) u64 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid && sel64), .req_ready(r64_ready),
    .req_is_store(req_is_store), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(r64_rv), .resp_rdata(r64_rdata), .resp_misaligned(r64_mis),
    .resp_illegal(r64_ill), .resp_bus_error(r64_berr),
    .mem_req(r64_req), .mem_we(r64_we), .mem_addr(r64_addr), .mem_wdata(r64_wdata),
    .mem_be(r64_be), .mem_gnt(mem_gnt && sel64), .mem_rvalid(mem_rvalid && sel64),
    .mem_rdata(mem_rdata)
  );

  assign o_ready = sel64 ? r64_ready : r32_ready;
  assign o_rv    = sel64 ? r64_rv    : r32_rv;
  assign o_mis   = sel64 ? r64_mis   : r32_mis;
  assign o_ill   = sel64 ? r64_ill   : r32_ill;
  assign o_berr  = sel64 ? r64_berr  : r32_berr;
  assign o_req   = sel64 ? r64_req   : r32_req;
  assign o_we    = sel64 ? r64_we    : r32_we;
  assign o_rdata = sel64 ? r64_rdata : {32'h0, r32_rdata};
  assign o_wdata = sel64 ? r64_wdata : {32'h0, r32_wdata};
  assign o_addr  = sel64 ? r64_addr  : r32_addr;
  assign o_be    = sel64 ? r64_be    : {4'h0, r32_be};

  typedef struct {
    bit          x64;
    bit          st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [63:0] wdata;
    int          gnt_dly;
    logic [63:0] rdata;
    bit          e_mem;
    logic [31:0] e_addr;
    logic [7:0]  e_be;
    logic [63:0] e_wdata;
    logic [63:0] e_rdata;
    bit          e_mis;
    bit          e_ill;
    bit          e_berr;
    int          e_lat;
  } vec_t;

  vec_t vecs[$];
  int checks   = 0;
  int failures = 0;

  function automatic vec_t mk(bit x64, bit st, logic [2:0] f3, logic [31:0] addr,
                              logic [63:0] wdata, int dly, logic [63:0] rdata, bit e_mem,
                              logic [31:0] e_addr, logic [7:0] e_be, logic [63:0] e_wdata,
                              logic [63:0] e_rdata, bit e_mis, bit e_ill, bit e_berr, int e_lat);
    vec_t v;
    v.x64 = x64; v.st = st; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.gnt_dly = dly;
    v.rdata = rdata; v.e_mem = e_mem; v.e_addr = e_addr; v.e_be = e_be; v.e_wdata = e_wdata;
    v.e_rdata = e_rdata; v.e_mis = e_mis; v.e_ill = e_ill; v.e_berr = e_berr; v.e_lat = e_lat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int    cyc, req_cyc;
    bit    seen_req, gnt_last, done;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    sel64 = v.x64; req_valid = 1'b1; req_is_store = v.st; req_funct3 = v.f3;
    req_addr = v.addr; req_wdata = v.wdata;
    @(negedge clk);
    req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'd0; req_addr = '0; req_wdata = '0;
    cyc = 1; req_cyc = 0; seen_req = 0; gnt_last = 0; done = 0;
    while (!done && cyc < 60) begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      if (gnt_last) begin
        chk({tag, "_req_drop"}, 64'(o_req), 64'd0);
        if (!v.st) begin
          mem_rvalid = 1'b1;
          mem_rdata  = v.rdata;
        end
      end
      gnt_last = 0;
      if (o_rv) begin
        done = 1;
        chk({tag, "_latency"}, 64'(cyc), 64'(v.e_lat));
        chk({tag, "_rdata"}, o_rdata, v.e_rdata);
        chk({tag, "_misaligned"}, 64'(o_mis), 64'(v.e_mis));
        chk({tag, "_illegal"}, 64'(o_ill), 64'(v.e_ill));
        chk({tag, "_bus_error"}, 64'(o_berr), 64'(v.e_berr));
        chk({tag, "_mem_issued"}, 64'(seen_req), 64'(v.e_mem));
      end else if (o_req) begin
        seen_req = 1;
        chk({tag, "_mem_addr"}, 64'(o_addr), 64'(v.e_addr));
        chk({tag, "_mem_be"}, 64'(o_be), 64'(v.e_be));
        chk({tag, "_mem_we"}, 64'(o_we), 64'(v.st));
        chk({tag, "_mem_wdata"}, o_wdata, v.e_wdata);
        if (req_cyc == v.gnt_dly) begin
          mem_gnt  = 1'b1;
          gnt_last = 1;
        end
        req_cyc++;
      end
      if (!done) begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got no resp_valid expected one within 60 cycles", tag);
    end else begin
      @(negedge clk);
      chk({tag, "_pulse_end"}, 64'(o_rv), 64'd0);
      chk({tag, "_ready_after"}, 64'(o_ready), 64'd1);
      chk({tag, "_idle_flags"}, {o_rdata[62:0], o_mis | o_ill | o_berr}, 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; sel64 = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'd0;
    req_addr = '0; req_wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    //      x64 st f3  addr          wdata                  dly rdata                    mem e_addr        be     e_wdata                e_rdata                mis ill be lat
    vecs.push_back(mk(0, 0, 3'd0, 32'h1003, 64'h0,                 0, 64'h80112233,           1, 32'h1000, 8'h08, 64'h0,                 64'hFFFFFF80,          0, 0, 0, 3));
    vecs.push_back(mk(0, 0, 3'd4, 32'h1003, 64'h0,                 0, 64'h80112233,           1, 32'h1000, 8'h08, 64'h0,                 64'h00000080,          0, 0, 0, 3));
    vecs.push_back(mk(0, 1, 3'd1, 32'h2002, 64'h0000ABCD,          3, 64'h0,                  1, 32'h2000, 8'h0C, 64'hABCD0000,          64'h0,                 0, 0, 0, 5));
    vecs.push_back(mk(0, 0, 3'd2, 32'h1001, 64'h0,                 0, 64'h0,                  0, 32'h0,    8'h00, 64'h0,                 64'h0,                 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 3'd3, 32'h1001, 64'h0,                 0, 64'h0,                  0, 32'h0,    8'h00, 64'h0,                 64'h0,                 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 3'd1, 32'h1002, 64'h0,                 1, 64'h80112233,           1, 32'h1000, 8'h0C, 64'h0,                 64'hFFFF8011,          0, 0, 0, 4));
    vecs.push_back(mk(0, 0, 3'd5, 32'h1000, 64'h0,                 0, 64'h80112233,           1, 32'h1000, 8'h03, 64'h0,                 64'h00002233,          0, 0, 0, 3));
    vecs.push_back(mk(0, 1, 3'd2, 32'h3000, 64'hDEADBEEF,          0, 64'h0,                  1, 32'h3000, 8'h0F, 64'hDEADBEEF,          64'h0,                 0, 0, 0, 2));
    vecs.push_back(mk(0, 1, 3'd0, 32'h3001, 64'h000000A5,          0, 64'h0,                  1, 32'h3000, 8'h02, 64'h0000A500,          64'h0,                 0, 0, 0, 2));
    vecs.push_back(mk(0, 1, 3'd4, 32'h3000, 64'h0,                 0, 64'h0,                  0, 32'h0,    8'h00, 64'h0,                 64'h0,                 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 3'd6, 32'h1000, 64'h0,                 0, 64'h0,                  0, 32'h0,    8'h00, 64'h0,                 64'h0,                 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 3'd7, 32'h1000, 64'h0,                 0, 64'h0,                  0, 32'h0,    8'h00, 64'h0,                 64'h0,                 0, 1, 0, 1));
    vecs.push_back(mk(0, 1, 3'd1, 32'h3001, 64'h1234,              0, 64'h0,                  0, 32'h0,    8'h00, 64'h0,                 64'h0,                 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 3'd0, 32'h1001, 64'h0,                 0, 64'h80112233,           1, 32'h1000, 8'h02, 64'h0,                 64'h00000022,          0, 0, 0, 3));
    vecs.push_back(mk(1, 0, 3'd6, 32'h0104, 64'h0,                 0, 64'hFFFFFFFF_00000000,  1, 32'h0100, 8'hF0, 64'h0,                 64'h00000000_FFFFFFFF, 0, 0, 0, 3));
    vecs.push_back(mk(1, 1, 3'd3, 32'h0108, 64'h01234567_89ABCDEF, 0, 64'h0,                  1, 32'h0108, 8'hFF, 64'h01234567_89ABCDEF, 64'h0,                 0, 0, 0, 2));
    vecs.push_back(mk(1, 0, 3'd3, 32'h0100, 64'h0,                 1, 64'h80000000_00000001,  1, 32'h0100, 8'hFF, 64'h0,                 64'h80000000_00000001, 0, 0, 0, 4));
    vecs.push_back(mk(1, 0, 3'd2, 32'h0104, 64'h0,                 0, 64'h80000000_12345678,  1, 32'h0100, 8'hF0, 64'h0,                 64'hFFFFFFFF_80000000, 0, 0, 0, 3));
    vecs.push_back(mk(1, 0, 3'd3, 32'h0104, 64'h0,                 0, 64'h0,                  0, 32'h0,    8'h00, 64'h0,                 64'h0,                 1, 0, 0, 1));
    vecs.push_back(mk(1, 1, 3'd7, 32'h0100, 64'h0,                 0, 64'h0,                  0, 32'h0,    8'h00, 64'h0,                 64'h0,                 0, 1, 0, 1));
    vecs.push_back(mk(1, 1, 3'd0, 32'h010F, 64'h5A,                0, 64'h0,                  1, 32'h0108, 8'h80, 64'h5A000000_00000000, 64'h0,                 0, 0, 0, 2));
`ifdef LSU_BUS_TIMEOUT_EN
    vecs.push_back(mk(0, 1, 3'd2, 32'h4000, 64'h11,              999, 64'h0,                  1, 32'h4000, 8'h0F, 64'h11,                64'h0,                 0, 0, 1, 5));
`endif

    #1;
    chk("reset_ready32", 64'(r32_ready), 64'd1);
    chk("reset_ready64", 64'(r64_ready), 64'd1);
    chk("reset_outputs32", {r32_rv, r32_mis, r32_ill, r32_berr, r32_req, r32_we, r32_be, r32_rdata}, 64'd0);
    chk("reset_outputs64", {r64_rv, r64_req, r64_we, r64_be, r64_rdata[31:0]}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(i, vecs[i]);
    end

    // Reset while a load waits for read data: the op is dropped without a response.
    @(negedge clk);
    sel64 = 1'b0; req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'd2; req_addr = 32'h1000;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_seq_req", 64'(o_req), 64'd1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("rst_seq_wait_r_req", 64'(o_req), 64'd0);
    chk("rst_seq_wait_r_ready", 64'(o_ready), 64'd0);
    #1 rst = 1'b1;
    #1;
    chk("rst_seq_ready_now", 64'(o_ready), 64'd1);
    chk("rst_seq_req_now", 64'(o_req), 64'd0);
    chk("rst_seq_no_resp", 64'(o_rv), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("rst_seq_quiet%0d", k), 64'(o_rv), 64'd0);
    end
    run_vec(100, mk(0, 1, 3'd0, 32'h2000, 64'h7E, 0, 64'h0, 1, 32'h2000, 8'h01, 64'h7E, 64'h0, 0, 0, 0, 2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Parametrised memory-stage access unit; sits between execute and writeback.
- Takes one load/store op at a time, drives a grant/valid data-memory bus, and returns a sign- or zero-extended load result or a store completion.
- Generalises access handling to XLEN 32 or 64 (adds LD/SD/LWU), with byte-lane steering, misalignment and illegal-op detection, and a multi-cycle handshake FSM.

Parameters:
- XLEN, 32, datapath width; only 32 or 64 legal.
- ADDR_WIDTH, 32, byte address width.
- TIMEOUT_CYCLES, 16, bus wait limit; used only with LSU_BUS_TIMEOUT_EN.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- req_valid  input  1  op presented by execute.
- req_ready  output  1  unit can accept an op.
- req_is_store  input  1  1 = store, 0 = load.
- req_funct3  input  3  RISC-V load/store funct3.
- req_addr  input  ADDR_WIDTH  byte address.
- req_wdata  input  XLEN  store data, right-aligned.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  XLEN  extended load data; 0 for stores and faults.
- resp_misaligned  output  1  address misaligned for access size.
- resp_illegal  output  1  funct3 invalid for direction/XLEN.
- resp_bus_error  output  1  bus timeout; constant 0 without macro.
- mem_req  output  1  bus request.
- mem_we  output  1  write enable.
- mem_addr  output  ADDR_WIDTH  word-aligned address (low log2(XLEN/8) bits zero).
- mem_wdata  output  XLEN  lane-steered store data.
- mem_be  output  XLEN/8  byte enables.
- mem_gnt  input  1  request accepted.
- mem_rvalid  input  1  read data valid.
- mem_rdata  input  XLEN  read data.

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0 except req_ready = 1; latched request cleared.
- States: IDLE, REQ, WAIT_R, RESP.
- req_ready = (state == IDLE). Accept on req_valid && req_ready; latch is_store, funct3, addr, wdata.
- Decode on accept; offset = addr[log2(XLEN/8)-1:0].
  - Loads: LB 0, LH 1, LW 2, LBU 4, LHU 5. LD 3 and LWU 6 are legal only when XLEN = 64. Load funct3 7 is illegal.
  - Stores: SB 0, SH 1, SW 2. SD 3 is legal only when XLEN = 64. All other store funct3 values are illegal.
  - Misaligned: half with offset[0] != 0; word with offset[1:0] != 0; double with offset[2:0] != 0.
  - Illegal takes priority over misaligned.
- IDLE -> RESP on a faulting op: no mem_req is issued; the relevant flag is set and resp_rdata = 0.
- IDLE -> REQ on a clean op.
- REQ: mem_req = 1, mem_we = is_store; mem_addr, mem_wdata and mem_be are held stable until mem_gnt.
  - mem_wdata = wdata << (8*offset).
  - mem_be = size mask (1, 3, 0xF or 0xFF) << offset.
  - Loads drive mem_be with the same mask.
- On mem_gnt: a store goes to RESP; a load goes to WAIT_R. mem_req drops the cycle after the grant.
- WAIT_R: on mem_rvalid, extract byte/half/word at offset, sign-extend (LB/LH/LW/LD) or zero-extend (LBU/LHU/LWU), register the result, go to RESP.
  - mem_rvalid is never expected in the same cycle as mem_gnt.
- RESP: resp_valid = 1 for exactly one cycle, with flags/data registered; next state IDLE. Execute takes no backpressure.
- Latency:
  - Zero-wait store: accept at cycle 0, mem_req/gnt at cycle 1, resp at cycle 2.
  - Zero-wait load: rvalid at cycle 2, resp at cycle 3.
  - Faulting op: resp at cycle 1.
- mem_rvalid while not in WAIT_R is ignored.
- Reset mid-transaction abandons the op with no response. The bench must not assert a late rvalid after reset release.
- Flags and resp_rdata are 0 whenever resp_valid = 0.

Optional Feature:
- Macro: LSU_BUS_TIMEOUT_EN.
- With the macro: a counter clears on entry to REQ/WAIT_R and increments each cycle in those states. On reaching TIMEOUT_CYCLES without gnt/rvalid respectively, the unit goes to RESP with resp_bus_error = 1 and resp_rdata = 0, and mem_req drops.
- Without the macro: no counter; the unit waits indefinitely and resp_bus_error is tied to 0.

Test Plan:
- XLEN=32, LB addr 0x1003, gnt immediate, rvalid next cycle with rdata 0x80112233 -> mem_addr 0x1000, mem_be 4'b1000, mem_we 0; resp_valid at cycle 3, resp_rdata 0xFFFFFF80. Repeat as LBU -> 0x00000080.
- XLEN=32, SH addr 0x2002, wdata 0x0000ABCD, gnt delayed 3 cycles -> mem_wdata 0xABCD0000, mem_be 4'b1100, mem_we 1, outputs stable through the stall; resp_valid one cycle after gnt, resp_rdata 0.
- XLEN=32, LW addr 0x1001 -> no mem_req, resp_valid at cycle 1 with resp_misaligned 1. LD (funct3 3) -> resp_illegal 1, resp_misaligned 0.
- XLEN=64, LWU addr 0x104, rdata 0xFFFFFFFF_00000000 -> mem_be 8'hF0, resp_rdata 0x00000000_FFFFFFFF. SD addr 0x108 -> mem_be 8'hFF.
- Load accepted and granted, rst pulsed in WAIT_R -> mem_req 0 and req_ready 1 immediately, no resp_valid; a following SB completes normally.
- With LSU_BUS_TIMEOUT_EN and TIMEOUT_CYCLES=4, gnt never asserted -> resp_valid with resp_bus_error 1 after 4 cycles in REQ, then req_ready 1.
